// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract: processes WIDTH operand bits LSB-first, one per clock, with a registered carry chain.
// Latency WIDTH+1 cycles from accepted start to done; start is ignored while busy, accepted in IDLE or DONE.
module serial_addsub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, sum_q, result_q;
    logic [CNT_W-1:0] cnt_q;
    logic             mode_q, carry_q, carry_out_q, overflow_q, busy_q, done_q;

    logic             bx_d, s_d, carry_d;
    logic [WIDTH-1:0] sum_d;

    // Full-adder bit slice; subtraction inverts B and relies on carry seeded with mode.
    always_comb begin
        bx_d    = b_q[0] ^ mode_q;
        s_d     = a_q[0] ^ bx_d ^ carry_q;
        carry_d = (a_q[0] & bx_d) | (a_q[0] & carry_q) | (bx_d & carry_q);
        sum_d   = {s_d, sum_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            mode_q      <= 1'b0;
            carry_q     <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                SHIFT: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    sum_q   <= sum_d;
                    carry_q <= carry_d;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        result_q    <= sum_d;
                        carry_out_q <= carry_d;
                        // carry_q here is the carry into the MSB
                        overflow_q  <= carry_q ^ carry_d;
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                    end
                end
                default: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a_in;
                        b_q     <= b_in;
                        mode_q  <= mode;
                        carry_q <= mode;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Scoreboarded bench for serial_addsub_ctrl: directed boundary cases, abort/ignore cases, random sweep.
module tb_serial_addsub_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, start, mode;
    logic [W-1:0] a_in, b_in;
    logic         busy, done, carry_out, overflow;
    logic [W-1:0] result;

    int total = 0;
    int bad   = 0;

    logic [W+1:0] exp_q[$];   // {result, carry_out, overflow}

    serial_addsub_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .a_in(a_in), .b_in(b_in), .busy(busy), .done(done),
        .result(result), .carry_out(carry_out), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Reference: integer arithmetic on unsigned and signed views of the operands.
    function automatic logic [W+1:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
        int ua, ub, ur, sa, sb, sr;
        logic [W-1:0] r;
        logic co, ov;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        ur = m ? ua - ub : ua + ub;
        sr = m ? sa - sb : sa + sb;
        r  = ur[W-1:0];
        co = m ? (ua >= ub) : (ur > 255);
        ov = (sr > 127) || (sr < -128);
        return {r, co, ov};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Presents start for one edge (E0); returns just after E0.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
        a_in = a; b_in = b; mode = m; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a_in = $urandom; b_in = $urandom; mode = $urandom_range(0, 1);
    endtask

    // Returns the number of edges until done is seen high; bounded.
    task automatic wait_done(output int n);
        n = 0;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (done) break;
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected one", n);
        end
    endtask

    // Monitor: compares every done against the scoreboard and checks the busy run length before it.
    int busy_run = 0;
    always @(negedge clk) begin
        if (busy) begin
            busy_run++;
        end else begin
            if (done) begin
                total++;
                if (busy_run != W) begin
                    bad++;
                    $display("FAIL busy_len: got %0d busy cycles, expected %0d", busy_run, W);
                end
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_done: got done with result 0x%0h, expected none", result);
                end else begin
                    logic [W+1:0] e;
                    e = exp_q.pop_front();
                    if ({result, carry_out, overflow} !== e) begin
                        bad++;
                        $display("FAIL result: got res=0x%0h co=%0b ov=%0b expected res=0x%0h co=%0b ov=%0b",
                                 result, carry_out, overflow, e[W+1:2], e[1], e[0]);
                    end
                end
            end
            busy_run = 0;
        end
    end

    typedef struct {
        logic [W-1:0] a, b;
        logic         m;
        logic [W-1:0] r;
        logic         co, ov;
    } vec_t;

    vec_t vecs[6] = '{
        '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0},
        '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0},
        '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1},
        '{8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0},
        '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0},
        '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1}
    };

    initial begin
        int n;
        logic [W-1:0] ra, rb;
        logic rm;
        rst = 1'b1; start = 1'b0; mode = 1'b0; a_in = '0; b_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {busy, done, result, carry_out, overflow}, '0);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            exp_q.push_back({vecs[i].r, vecs[i].co, vecs[i].ov});
            issue(vecs[i].a, vecs[i].b, vecs[i].m);
            chk("busy_after_start", busy, 1'b1);
            wait_done(n);
            chk("latency", n, W);
            @(posedge clk); #1;
            chk("done_one_cycle", done, 1'b0);
        end

        // Start while busy is ignored; start held in DONE is accepted back-to-back.
        exp_q.push_back({8'h30, 1'b0, 1'b0});
        issue(8'h10, 8'h20, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        issue(8'hAA, 8'h55, 1'b1);
        wait_done(n);
        chk("latency_ignored_start", n, W - 3);
        exp_q.push_back({8'h02, 1'b0, 1'b0});
        issue(8'h01, 8'h01, 1'b0);
        chk("busy_back_to_back", busy, 1'b1);
        wait_done(n);
        chk("latency_back_to_back", n, W);

        // Mid-operation reset aborts with no done.
        issue(8'h33, 8'h44, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_state", {busy, done, result, carry_out, overflow}, '0);
        repeat (12) begin @(posedge clk); #1; end
        chk("abort_no_done_result", result, 8'h00);
        exp_q.push_back({8'h03, 1'b0, 1'b0});
        issue(8'h01, 8'h02, 1'b0);
        wait_done(n);
        chk("latency_after_abort", n, W);

        // Random sweep, alternating back-to-back and idle gaps.
        for (int k = 0; k < 500; k++) begin
            ra = $urandom; rb = $urandom; rm = $urandom_range(0, 1);
            exp_q.push_back(ref_model(ra, rb, rm));
            issue(ra, rb, rm);
            wait_done(n);
            if (n != W) chk("latency_rand", n, W);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            end
        end

        repeat (3) begin @(posedge clk); #1; end
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_addsub_ctrl.md
Name: serial_addsub_ctrl

Overview:
- Multi-bit, bit-serial add/subtract stage that sits directly above the 1-bit universal add/sub cell.
- Accepts two WIDTH-bit operands and a mode bit, then processes one bit per clock, LSB first, with a registered carry/borrow chain.
- Presents the assembled result with carry and signed-overflow flags and a one-cycle done strobe.
- Contains its own full-adder bit slice (carry-in required), applied as A + B (mode=0) or A + ~B + 1 (mode=1).

Parameters:
- WIDTH, 8, operand/result width in bits (min 2).

Ports:
- clk  input  1  rising-edge clock (single clock domain)
- rst  input  1  synchronous, active-high reset
- start  input  1  request to begin an operation; sampled only when busy=0
- mode  input  1  0=add, 1=subtract (a_in - b_in); captured with start
- a_in  input  WIDTH  operand A; captured with start
- b_in  input  WIDTH  operand B; captured with start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle strobe; result/flags valid
- result  output  WIDTH  sum/difference, two's complement
- carry_out  output  1  final carry out of MSB (sub: 1 = no borrow, A>=B unsigned)
- overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset: state=IDLE; busy, done, result, carry_out, overflow all 0; internal shift regs, carry and counter cleared. rst has priority over start. Asserting rst mid-operation aborts it, with no done strobe.
- States: IDLE, SHIFT, DONE.
- IDLE/DONE: if start=1 at an edge, the block:
  - loads A<=a_in, B<=b_in, mode_r<=mode;
  - sets carry<=mode, cnt<=0;
  - goes to SHIFT.
  - Otherwise DONE returns to IDLE; IDLE holds.
- SHIFT, each edge:
  - bx = B[0]^mode_r; s = A[0]^bx^carry;
  - carry <= maj(A[0], bx, carry);
  - sum shift reg shifts right with s into MSB; A, B shift right; cnt++.
- SHIFT, on the edge where cnt==WIDTH-1:
  - result <= {s, sum[WIDTH-1:1]};
  - carry_out <= new carry;
  - overflow <= carry-in of this bit XOR new carry;
  - go to DONE.
- busy=1 exactly when state==SHIFT. done=1 exactly when state==DONE (one cycle).
- Latency: start sampled at edge E0 -> bits processed at E1..E_WIDTH -> done high in the cycle after E_WIDTH. Throughput: one operation per WIDTH+1 cycles; back-to-back start during the DONE cycle is accepted.
- start while busy=1 is ignored; operands and mode changes while busy have no effect.
- result/carry_out/overflow change only at DONE entry and hold until the next completion or reset. Intermediate bits are never visible.
- Arithmetic is modulo 2^WIDTH. No saturation.

Test Plan:
- WIDTH=8, add, a=0x05 b=0x03 start at E0 -> busy high E1..E8; done=1 only in the cycle after E8; result=0x08, carry_out=0, overflow=0.
- Add boundaries:
  - 0xFF+0x01 -> 0x00, carry_out=1, overflow=0.
  - 0x7F+0x01 -> 0x80, carry_out=0, overflow=1.
- Subtract:
  - 0x05-0x05 -> 0x00, carry_out=1, overflow=0.
  - 0x00-0x01 -> 0xFF, carry_out=0, overflow=0.
  - 0x80-0x01 -> 0x7F, carry_out=1, overflow=1.
- Start 0x10+0x20, then pulse start at E3 with a=0xAA b=0x55 mode=1 -> ignored; done after E8 with result=0x30. A start held in the DONE cycle with 0x01+0x01 -> next done 9 cycles later with result=0x02.
- Start 0x33+0x44, assert rst for one cycle at E4 -> after that edge busy=0, done=0, result=0x00, flags 0; no done strobe follows. Fresh start 0x01+0x02 -> result=0x03.
- Random sweep: 500 operand/mode triples vs. reference model (a±b mod 256, carry, signed overflow). Every done preceded by exactly 8 busy cycles.
